uart_rx: RTL and testbench

- UART receiver: 8N1 frames, LSB first, sampled at mid-bit from a free-running system clock.
- Recovers each byte and presents it with a one-cycle valid strobe. Reports framing errors.
- Sits between the external RX pin and the receive FIFO; the companion of the existing UART transmitter (same baud settings, same 50 MHz clock).

---
 rtl/uart_pkg.sv | 11 +
 rtl/uart_rx_bit_timer.sv | 22 ++
 rtl/uart_rx.sv | 128 ++++++++++++
 tb/tb_uart_rx.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART constants and receiver FSM state encoding
package uart_pkg;
  localparam int DATA_W       = 8;
  localparam int HALF_BIT_DEF = 217;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } rx_state_e;
endpackage

// File: rtl/uart_rx_bit_timer.sv
// uart_rx_bit_timer: bit-period counter with clear, half-bit and full-bit ticks
// Ports: clk, rst (sync, active-high), clr (zero the counter this cycle),
//        half (count == HALF_AT), full (count == 2*HALF_BIT_CYC-1).
module uart_rx_bit_timer #(
  parameter int HALF_BIT_CYC = 217,
  parameter int CNT_WIDTH    = 9,
  parameter int HALF_AT      = HALF_BIT_CYC - 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic half,
  output logic full
);
  localparam logic [CNT_WIDTH-1:0] HALF_V = CNT_WIDTH'(HALF_AT);
  localparam logic [CNT_WIDTH-1:0] FULL_V = CNT_WIDTH'(2 * HALF_BIT_CYC - 1);
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  assign half = cnt_q == HALF_V;
  assign full = cnt_q == FULL_V;
  always_comb cnt_d = clr ? '0 : cnt_q + CNT_WIDTH'(1);
  always_ff @(posedge clk) cnt_q <= rst ? '0 : cnt_d;
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver sampling at mid-bit, with framing-error reporting
// Ports: clk, rst (sync, active-high), rx (async serial line, idle high),
//        rx_dat (last good byte), rx_vld (1-cycle strobe), frame_err (1-cycle
//        strobe on low stop bit), busy (FSM not idle).
// Macro UART_RX_MAJORITY_EN: 2-of-3 vote around each mid-bit, one cycle later.
module uart_rx
  import uart_pkg::*;
#(
  parameter int HALF_BIT_CYC = HALF_BIT_DEF,
  parameter int CNT_WIDTH    = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx,
  output logic [DATA_W-1:0] rx_dat,
  output logic              rx_vld,
  output logic              frame_err,
  output logic              busy
);
  rx_state_e         state_q, state_d;
  logic              sync1_q, sync2_q, rx_prev_q;
  logic [1:0]        warm_q, warm_d;
  logic              armed_q, armed_d;
  logic [2:0]        idx_q, idx_d;
  logic [DATA_W-1:0] sh_q, sh_d;
  logic              fin_q, fin_d, stop_q, stop_d;
  logic [DATA_W-1:0] rx_dat_q, rx_dat_d;
  logic              rx_vld_q, rx_vld_d, frame_err_q, frame_err_d, busy_q, busy_d;
  logic              rx_s, smp, clr, half, full;
  assign rx_s = sync2_q;
`ifdef UART_RX_MAJORITY_EN
  localparam int HALF_AT = HALF_BIT_CYC;
  logic [1:0] hist_q, hist_d;
  always_comb hist_d = {hist_q[0], rx_s};
  always_ff @(posedge clk) hist_q <= rst ? 2'b11 : hist_d;
  assign smp = (hist_q[1] & hist_q[0]) | (hist_q[1] & rx_s) | (hist_q[0] & rx_s);
`else
  localparam int HALF_AT = HALF_BIT_CYC - 1;
  assign smp = rx_s;
`endif
  uart_rx_bit_timer #(
    .HALF_BIT_CYC(HALF_BIT_CYC),
    .CNT_WIDTH   (CNT_WIDTH),
    .HALF_AT     (HALF_AT)
  ) u_timer (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .half(half),
    .full(full)
  );
  // The synchronizer resets high, so a line low at reset release would look
  // like a falling edge; starts are only armed once the real line is seen high.
  always_comb begin
    warm_d  = {warm_q[0], 1'b1};
    armed_d = armed_q | (warm_q[1] & rx_s);
    state_d = state_q;
    idx_d   = idx_q;
    clr     = 1'b0;
    fin_d   = 1'b0;
    stop_d  = stop_q;
    case (state_q)
      ST_IDLE: begin
        clr = 1'b1;
        if (armed_q && !rx_s && rx_prev_q) state_d = ST_START;
      end
      ST_START: if (half) begin
        clr     = 1'b1;
        idx_d   = 3'd0;
        state_d = smp ? ST_IDLE : ST_DATA;
      end
      ST_DATA: if (full) begin
        clr     = 1'b1;
        idx_d   = idx_q + 3'd1;
        state_d = idx_q == 3'(DATA_W - 1) ? ST_STOP : ST_DATA;
      end
      ST_STOP: if (full) begin
        clr     = 1'b1;
        fin_d   = 1'b1;
        stop_d  = smp;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    sh_d        = (state_q == ST_DATA && full) ? {smp, sh_q[DATA_W-1:1]} : sh_q;
    rx_vld_d    = fin_q & stop_q;
    frame_err_d = fin_q & ~stop_q;
    rx_dat_d    = (fin_q & stop_q) ? sh_q : rx_dat_q;
    busy_d      = state_q != ST_IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      rx_prev_q   <= 1'b1;
      warm_q      <= 2'b00;
      armed_q     <= 1'b0;
      state_q     <= ST_IDLE;
      idx_q       <= 3'd0;
      sh_q        <= '0;
      fin_q       <= 1'b0;
      stop_q      <= 1'b0;
      rx_dat_q    <= '0;
      rx_vld_q    <= 1'b0;
      frame_err_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      sync1_q     <= rx;
      sync2_q     <= sync1_q;
      rx_prev_q   <= rx_s;
      warm_q      <= warm_d;
      armed_q     <= armed_d;
      state_q     <= state_d;
      idx_q       <= idx_d;
      sh_q        <= sh_d;
      fin_q       <= fin_d;
      stop_q      <= stop_d;
      rx_dat_q    <= rx_dat_d;
      rx_vld_q    <= rx_vld_d;
      frame_err_q <= frame_err_d;
      busy_q      <= busy_d;
    end
  end
  assign rx_dat    = rx_dat_q;
  assign rx_vld    = rx_vld_q;
  assign frame_err = frame_err_q;
  assign busy      = busy_q;
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed, table-driven self-checking bench for uart_rx
module tb_uart_rx;
  localparam int H = 217;
`ifdef UART_RX_MAJORITY_EN
  localparam int LAT = 4;
  localparam logic [7:0] GLITCH_EXP = 8'hC3;
`else
  localparam int LAT = 3;
  localparam logic [7:0] GLITCH_EXP = 8'h3C;
`endif
  logic clk = 1'b0, rst = 1'b1, rx = 1'b1;
  logic [7:0] rx_dat;
  logic rx_vld, frame_err, busy;
  int cyc = 0, n_chk = 0, n_fail = 0;
  int rise_cyc = -1, fall_cyc = -1;
  logic busy_prev = 1'b0;
  typedef struct {int cyc; bit vld; bit ferr; logic [7:0] dat;} ev_t;
  typedef struct {logic [7:0] dat; logic stop; logic [7:0] exp_dat;} vec_t;
  ev_t evq[$];
  vec_t tbl[6];

  uart_rx #(.HALF_BIT_CYC(H), .CNT_WIDTH(9)) dut (
    .clk(clk), .rst(rst), .rx(rx),
    .rx_dat(rx_dat), .rx_vld(rx_vld), .frame_err(frame_err), .busy(busy)
  );

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rx_vld || frame_err) evq.push_back('{cyc, rx_vld, frame_err, rx_dat});
    busy_prev <= busy;
    if (busy && !busy_prev) rise_cyc <= cyc;
    if (!busy && busy_prev) fall_cyc <= cyc;
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] d, input logic stop, input bit glitch,
                      input int rst_from, output int t0);
    logic [9:0] f;
    f  = {stop, d, 1'b0};
    t0 = cyc + 1;
    for (int b = 0; b < 10; b++)
      for (int k = 0; k < 2 * H; k++) begin
        rx = (glitch && b >= 1 && b <= 8 && k == H) ? ~f[b] : f[b];
        if (rst_from >= 0 && b * 2 * H + k >= rst_from) rst = 1'b1;
        @(negedge clk);
      end
  endtask

  task automatic expect_ev(input string nm, input int t, input bit vld, input logic [7:0] dat);
    ev_t ev;
    chk({nm, " pulses"}, evq.size(), 1);
    if (evq.size() > 0) begin
      ev = evq.pop_front();
      chk({nm, " cycle"}, ev.cyc, t);
      chk({nm, " rx_vld"}, int'(ev.vld), int'(vld));
      chk({nm, " frame_err"}, int'(ev.ferr), int'(!vld));
      chk({nm, " rx_dat"}, int'(ev.dat), int'(dat));
    end
    evq.delete();
  endtask

  initial begin
    int t0, t1;
    ev_t e0, e1;
    tbl[0] = '{8'h00, 1'b1, 8'h00};
    tbl[1] = '{8'hFF, 1'b1, 8'hFF};
    tbl[2] = '{8'h3C, 1'b0, 8'hFF};
    tbl[3] = '{8'h81, 1'b1, 8'h81};
    tbl[4] = '{8'h7E, 1'b0, 8'h81};
    tbl[5] = '{8'h5A, 1'b1, 8'h5A};
    repeat (5) @(negedge clk);
    chk("reset rx_dat", int'(rx_dat), 0);
    chk("reset rx_vld", int'(rx_vld), 0);
    chk("reset frame_err", int'(frame_err), 0);
    chk("reset busy", int'(busy), 0);
    rst = 1'b0;
    idle(20);
    chk("idle no pulse", evq.size(), 0);

    send(8'hA5, 1'b1, 1'b0, -1, t0);
    idle(6);
    expect_ev("clean A5", t0 + 19 * H + LAT, 1'b1, 8'hA5);
    chk("clean busy rise", rise_cyc, t0 + 3);
    chk("clean busy fall", fall_cyc, t0 + 19 * H + LAT);

    for (int i = 0; i < 6; i++) begin
      send(tbl[i].dat, tbl[i].stop, 1'b0, -1, t0);
      idle(6);
      expect_ev($sformatf("vec%0d", i), t0 + 19 * H + LAT, tbl[i].stop, tbl[i].exp_dat);
      chk($sformatf("vec%0d held rx_dat", i), int'(rx_dat), int'(tbl[i].exp_dat));
    end

    send(8'h00, 1'b1, 1'b0, -1, t0);
    send(8'hFF, 1'b1, 1'b0, -1, t1);
    idle(6);
    chk("b2b pulses", evq.size(), 2);
    if (evq.size() == 2) begin
      e0 = evq.pop_front();
      e1 = evq.pop_front();
      chk("b2b first cycle", e0.cyc, t0 + 19 * H + LAT);
      chk("b2b first dat", int'(e0.dat), 8'h00);
      chk("b2b second dat", int'(e1.dat), 8'hFF);
      chk("b2b spacing", e1.cyc - e0.cyc, 20 * H);
      chk("b2b vld both", int'(e0.vld & e1.vld), 1);
    end
    evq.delete();

    t0 = cyc + 1;
    rx = 1'b0;
    repeat (100) @(negedge clk);
    idle(600);
    chk("false start pulses", evq.size(), 0);
    chk("false start busy rise", rise_cyc, t0 + 3);
    chk("false start busy fall", fall_cyc, t0 + H + LAT);
    evq.delete();

    send(8'h3C, 1'b0, 1'b0, -1, t0);
    rx = 1'b0;
    repeat (3000) @(negedge clk);
    expect_ev("frame err", t0 + 19 * H + LAT, 1'b0, 8'hFF);
    chk("break busy", int'(busy), 0);
    chk("break rx_dat", int'(rx_dat), 8'hFF);
    idle(10);
    chk("break release pulses", evq.size(), 0);

    send(8'h55, 1'b1, 1'b0, 5 * 2 * H + H, t0);
    rst = 1'b0;
    idle(20);
    chk("abort pulses", evq.size(), 0);
    chk("abort rx_dat cleared", int'(rx_dat), 0);
    chk("abort busy", int'(busy), 0);
    evq.delete();
    send(8'h81, 1'b1, 1'b0, -1, t0);
    idle(6);
    expect_ev("after abort", t0 + 19 * H + LAT, 1'b1, 8'h81);

    send(8'hC3, 1'b1, 1'b1, -1, t0);
    idle(6);
    expect_ev("glitch C3", t0 + 19 * H + LAT, 1'b1, GLITCH_EXP);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
